// File: rtl/aibcr3aux_osc_en_ctrl.sv
// ---------------------------------------------------------------------------
// aibcr3aux_osc_en_ctrl
//
// Source-side enable controller for the AUX oscillator clock path. Drives the
// enable into the oscillator-domain enable synchronizer, holds it through a
// warm-up interval, waits for the synchronized enable to come back through a
// local 2-flop synchronizer, then reports the oscillator clock ready. Removing
// the request runs an orderly shutdown; missing or lost acknowledges raise a
// sticky timeout error that clears once the request is withdrawn.
//
// Parameters
//   WARM_CYC    warm-up cycles with osc_en high before the ack is examined
//   TO_CYC      acknowledge timeout in cycles (rise and fall)
//   CNT_W       width of the shared cycle counter
//
// Ports
//   clk          in   controller clock
//   resetb       in   asynchronous active-low reset
//   osc_req      in   level request for the oscillator clock (clk domain)
//   en_ack       in   returned enable, asynchronous to clk
//   osc_en       out  registered enable to the synchronizer d input
//   osc_rdy      out  registered, oscillator clock confirmed running
//   timeout_err  out  registered, acknowledge timeout or acknowledge loss
//   state        out  current FSM encoding for debug
// ---------------------------------------------------------------------------
module aibcr3aux_osc_en_ctrl #(
   parameter int WARM_CYC = 16,
   parameter int TO_CYC   = 64,
   parameter int CNT_W    = 8
) (
   input  logic       clk,
   input  logic       resetb,
   input  logic       osc_req,
   input  logic       en_ack,
   output logic       osc_en,
   output logic       osc_rdy,
   output logic       timeout_err,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WARMUP   = 3'd1,
      ST_WAIT_ACK = 3'd2,
      ST_READY    = 3'd3,
      ST_OFF      = 3'd4,
      ST_ERR      = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARM_CYC - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TO_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = 1;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             osc_en_q;
   logic             osc_rdy_q;
   logic             timeout_err_q;
   logic             ack_meta_q;
   logic             ack_s_q;

   // Counter never wraps; it holds at all-ones if ever driven that far.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == '1) begin
         return v;
      end
      return v + CNT_ONE;
   endfunction

   // en_ack crosses in from the oscillator domain; only ack_s_q is used.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         ack_meta_q <= 1'b0;
         ack_s_q    <= 1'b0;
      end else begin
         ack_meta_q <= en_ack;
         ack_s_q    <= ack_meta_q;
      end
   end

   // Control FSM with registered outputs. Every entry into OFF restarts the
   // counter so the shutdown timeout always gets its full TO_CYC window.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         osc_en_q      <= 1'b0;
         osc_rdy_q     <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               osc_en_q      <= 1'b0;
               osc_rdy_q     <= 1'b0;
               timeout_err_q <= 1'b0;
               if (osc_req) begin
                  state_q  <= ST_WARMUP;
                  osc_en_q <= 1'b1;
                  cnt_q    <= '0;
               end
            end

            ST_WARMUP: begin
               if (!osc_req) begin
                  state_q  <= ST_OFF;
                  osc_en_q <= 1'b0;
                  cnt_q    <= '0;
               end else if (cnt_q == WARM_LAST) begin
                  state_q <= ST_WAIT_ACK;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= sat_inc(cnt_q);
               end
            end

            ST_WAIT_ACK: begin
               // Shutdown outranks an acknowledge arriving in the same cycle.
               if (!osc_req) begin
                  state_q  <= ST_OFF;
                  osc_en_q <= 1'b0;
                  cnt_q    <= '0;
               end else if (ack_s_q) begin
                  state_q   <= ST_READY;
                  osc_rdy_q <= 1'b1;
               end else if (cnt_q == TO_LAST) begin
                  state_q       <= ST_ERR;
                  osc_en_q      <= 1'b0;
                  timeout_err_q <= 1'b1;
               end else begin
                  cnt_q <= sat_inc(cnt_q);
               end
            end

            ST_READY: begin
               if (!osc_req) begin
                  state_q   <= ST_OFF;
                  osc_en_q  <= 1'b0;
                  osc_rdy_q <= 1'b0;
                  cnt_q     <= '0;
               end else if (!ack_s_q) begin
                  // Acknowledge dropped while still requested: clock lost.
                  state_q       <= ST_ERR;
                  osc_en_q      <= 1'b0;
                  osc_rdy_q     <= 1'b0;
                  timeout_err_q <= 1'b1;
               end
            end

            ST_OFF: begin
               // A new request is only honoured once back in IDLE.
               osc_en_q <= 1'b0;
               if (!ack_s_q) begin
                  state_q <= ST_IDLE;
               end else if (cnt_q == TO_LAST) begin
                  state_q       <= ST_ERR;
                  timeout_err_q <= 1'b1;
               end else begin
                  cnt_q <= sat_inc(cnt_q);
               end
            end

            ST_ERR: begin
               osc_en_q      <= 1'b0;
               osc_rdy_q     <= 1'b0;
               timeout_err_q <= 1'b1;
               if (!osc_req) begin
                  state_q       <= ST_IDLE;
                  timeout_err_q <= 1'b0;
                  cnt_q         <= '0;
               end
            end

            default: begin
               state_q       <= ST_IDLE;
               cnt_q         <= '0;
               osc_en_q      <= 1'b0;
               osc_rdy_q     <= 1'b0;
               timeout_err_q <= 1'b0;
            end
         endcase
      end
   end

   assign osc_en      = osc_en_q;
   assign osc_rdy     = osc_rdy_q;
   assign timeout_err = timeout_err_q;
   assign state       = state_q;

endmodule

// File: tb/tb_aibcr3aux_osc_en_ctrl.sv
module tb_aibcr3aux_osc_en_ctrl;

   localparam int WARM_CYC = 16;
   localparam int TO_CYC   = 64;
   localparam int CNT_W    = 8;

   localparam int P_IDLE  = 0;
   localparam int P_WARM  = 1;
   localparam int P_WAIT  = 2;
   localparam int P_READY = 3;
   localparam int P_OFF   = 4;
   localparam int P_ERR   = 5;

   logic       clk     = 1'b0;
   logic       resetb  = 1'b0;
   logic       osc_req = 1'b0;
   logic       en_ack  = 1'b0;
   logic       osc_en;
   logic       osc_rdy;
   logic       timeout_err;
   logic [2:0] state;

   aibcr3aux_osc_en_ctrl #(
      .WARM_CYC (WARM_CYC),
      .TO_CYC   (TO_CYC),
      .CNT_W    (CNT_W)
   ) dut (
      .clk         (clk),
      .resetb      (resetb),
      .osc_req     (osc_req),
      .en_ack      (en_ack),
      .osc_en      (osc_en),
      .osc_rdy     (osc_rdy),
      .timeout_err (timeout_err),
      .state       (state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // en_ack source: 0 = held by the test, 1 = osc_en looped back with delay,
   // 2 = random level every cycle
   int         ack_mode = 0;
   int         ack_dly  = 3;
   logic [5:0] dl       = '0;

   // Reference model: phase plus time spent in that phase, and the ack history.
   int   m_phase = P_IDLE;
   int   m_age   = 0;
   logic m_meta  = 1'b0;
   logic m_acks  = 1'b0;

   typedef struct {
      int         n;
      logic       req;
      logic       ack;
      logic [2:0] st;
      logic       en;
      logic       rdy;
      logic       err;
   } vec_t;

   vec_t tbl[16];

   function automatic logic [5:0] dut_out();
      return {state, osc_en, osc_rdy, timeout_err};
   endfunction

   function automatic logic [5:0] model_out();
      logic en;
      en = (m_phase == P_WARM) || (m_phase == P_WAIT) || (m_phase == P_READY);
      return {3'(m_phase), en, m_phase == P_READY, m_phase == P_ERR};
   endfunction

   task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t st/en/rdy/err got %b want %b", name, $time, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = P_IDLE;
      m_age   = 0;
      m_meta  = 1'b0;
      m_acks  = 1'b0;
   endtask

   // One clock edge of the behavioural rules, using the inputs as sampled.
   task automatic model_edge();
      int nxt;
      if (!resetb) begin
         model_reset();
      end else begin
         nxt = m_phase;
         case (m_phase)
            P_IDLE:  if (osc_req) nxt = P_WARM;
            P_WARM:  if (!osc_req) nxt = P_OFF;
                     else if (m_age + 1 >= WARM_CYC) nxt = P_WAIT;
            P_WAIT:  if (!osc_req) nxt = P_OFF;
                     else if (m_acks) nxt = P_READY;
                     else if (m_age + 1 >= TO_CYC) nxt = P_ERR;
            P_READY: if (!osc_req) nxt = P_OFF;
                     else if (!m_acks) nxt = P_ERR;
            P_OFF:   if (!m_acks) nxt = P_IDLE;
                     else if (m_age + 1 >= TO_CYC) nxt = P_ERR;
            P_ERR:   if (!osc_req) nxt = P_IDLE;
            default: nxt = P_IDLE;
         endcase
         m_age   = (nxt == m_phase) ? m_age + 1 : 0;
         m_phase = nxt;
         m_acks  = m_meta;
         m_meta  = en_ack;
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      chk("model", dut_out(), model_out());
      dl = {dl[4:0], osc_en};
      case (ack_mode)
         1: en_ack = dl[ack_dly];
         2: en_ack = 1'($urandom_range(0, 1));
         default: ;
      endcase
   endtask

   // Reset asserted mid-cycle: outputs must clear without waiting for an edge.
   task automatic do_reset();
      #2;
      resetb = 1'b0;
      #1;
      chk("async_rst", dut_out(), 6'b0);
      model_reset();
      dl = '0;
      if (ack_mode == 1) en_ack = 1'b0;
      tick();
      resetb = 1'b1;
   endtask

   task automatic wait_rdy(input string name, output int n);
      n = 0;
      while (!osc_rdy && n < 60) begin
         tick();
         n++;
      end
      chk_int(name, osc_rdy, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int seen;
      int r;

      tbl[0]  = '{3,  1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1,  1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{15, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0};
      tbl[3]  = '{1,  1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{1,  1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{1,  1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{1,  1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0};
      tbl[7]  = '{1,  1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{5,  1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{2,  1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{1,  1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{80, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0};
      tbl[12] = '{1,  1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 1'b1};
      tbl[13] = '{4,  1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 1'b1};
      tbl[14] = '{1,  1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
      tbl[15] = '{2,  1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};

      repeat (2) @(posedge clk);
      #1;
      chk("reset", dut_out(), 6'b0);
      model_reset();
      resetb = 1'b1;

      // Table-driven walk through the state machine.
      ack_mode = 0;
      for (int i = 0; i < 16; i++) begin
         osc_req = tbl[i].req;
         en_ack  = tbl[i].ack;
         repeat (tbl[i].n) tick();
         chk($sformatf("tbl%0d", i), dut_out(),
             {tbl[i].st, tbl[i].en, tbl[i].rdy, tbl[i].err});
      end

      // Normal on/off with en_ack = osc_en delayed 3 cycles.
      do_reset();
      ack_mode = 1;
      ack_dly  = 3;
      osc_req  = 1'b1;
      tick();
      chk_int("on_en", osc_en, 1);
      n = 1;
      while (!osc_rdy && n < 40) begin
         tick();
         n++;
      end
      chk_int("on_rdy_lat", n, 18);
      repeat (3) tick();
      osc_req = 1'b0;
      tick();
      chk_int("off_fall", int'({osc_en, osc_rdy}), 0);
      n = 0;
      while (state != 3'd0 && n < 20) begin
         tick();
         n++;
      end
      chk_int("off_idle", n, 6);

      // Missing acknowledge.
      do_reset();
      ack_mode = 0;
      en_ack   = 1'b0;
      osc_req  = 1'b1;
      n = 0;
      while (!timeout_err && n < 200) begin
         tick();
         n++;
      end
      chk_int("to_lat", n, 81);
      chk_int("to_en", osc_en, 0);
      osc_req = 1'b0;
      tick();
      chk("to_clear", dut_out(), 6'b0);

      // Clock loss in READY.
      do_reset();
      ack_mode = 1;
      osc_req  = 1'b1;
      wait_rdy("loss_up", n);
      ack_mode = 0;
      en_ack   = 1'b0;
      n = 0;
      while (!timeout_err && n < 20) begin
         tick();
         n++;
      end
      chk_int("loss_lat", n, 3);
      chk_int("loss_rdy", osc_rdy, 0);
      osc_req = 1'b0;
      tick();
      chk_int("loss_idle", state, 0);

      // Stuck acknowledge during shutdown; request during OFF is ignored.
      do_reset();
      ack_mode = 1;
      osc_req  = 1'b1;
      wait_rdy("stuck_up", n);
      ack_mode = 0;
      en_ack   = 1'b1;
      osc_req  = 1'b0;
      tick();
      repeat (10) tick();
      osc_req = 1'b1;
      tick();
      chk_int("stuck_ign", state, 4);
      n = 11;
      while (state != 3'd5 && n < 200) begin
         tick();
         n++;
      end
      chk_int("stuck_off", n, 64);
      osc_req = 1'b0;
      en_ack  = 1'b0;
      tick();
      chk_int("stuck_clr", int'({state, timeout_err}), 0);

      // Early abort in WARMUP.
      do_reset();
      ack_mode = 1;
      osc_req  = 1'b1;
      tick();
      repeat (5) tick();
      osc_req = 1'b0;
      tick();
      chk_int("abort_en", int'({state, osc_en}), 8);
      seen = 0;
      n = 0;
      while (state != 3'd0 && n < 20) begin
         tick();
         n++;
         if (osc_rdy) seen = 1;
      end
      chk_int("abort_idle", state, 0);
      chk_int("abort_rdy", seen, 0);

      // Async reset from READY, then a fresh turn-on.
      do_reset();
      ack_mode = 1;
      osc_req  = 1'b1;
      wait_rdy("rst_up", n);
      repeat (2) tick();
      do_reset();
      osc_req = 1'b0;
      repeat (2) tick();
      osc_req = 1'b1;
      n = 0;
      while (!osc_rdy && n < 40) begin
         tick();
         n++;
      end
      chk_int("rst_relat", n, 18);

      // Randomized run against the reference model.
      do_reset();
      osc_req = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 29) == 0) osc_req = ~osc_req;
         if ($urandom_range(0, 49) == 0) begin
            r = int'($urandom_range(0, 9));
            if (r < 6) begin
               ack_mode = 1;
               ack_dly  = int'($urandom_range(0, 5));
            end else if (r < 8) begin
               ack_mode = 0;
               en_ack   = 1'($urandom_range(0, 1));
            end else begin
               ack_mode = 2;
            end
         end
         if ($urandom_range(0, 1499) == 0) do_reset();
         else tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
